// File: rtl/bank_arb_pkg.sv
// Shared types for the bank arbiter.
// State encoding, default widths, timeout counter width.
package bank_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int TMO_W  = 8;

endpackage

// File: rtl/bank_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches upward from ptr+1, wrapping, ptr itself last.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // first set request after ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!any && req[(int'(ptr) + i) % N]) begin
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_arbiter.sv
// Round-robin sequencer sharing one bank among N_REQ requesters.
// Optional sticky grant: define BANK_ARB_LOCK_EN to add req_lock.
module bank_arbiter
  import bank_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_write,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
`ifdef BANK_ARB_LOCK_EN
  input  logic [N_REQ-1:0]    req_lock,
`endif
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic                rsp_err,
  output logic                bank_read,
  output logic                bank_write,
  output logic [AW-1:0]       bank_addr,
  output logic [DW-1:0]       bank_wdata,
  input  logic [DW-1:0]       bank_rdata,
  input  logic                bank_finish
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  arb_state_t state, state_d;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    cur_w;
  logic             cur_wr;
  logic [TMO_W-1:0] cnt;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_any;

  logic accept;
  logic fin_ok;
  logic fin_err;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef BANK_ARB_LOCK_EN
  logic lock_q;
  logic lock_hit;

  assign lock_hit = lock_q && req_valid[cur_w];

  // sticky owner overrides the round-robin pick
  always_comb begin
    grant     = pick_gnt;
    grant_idx = pick_idx;
    grant_any = pick_any;
    if (lock_hit) begin
      grant     = ONE << cur_w;
      grant_idx = cur_w;
      grant_any = 1'b1;
    end
  end

  // lock set by a clean response, dropped otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else if (fin_ok) begin
      lock_q <= req_lock[cur_w];
    end else if (fin_err) begin
      lock_q <= 1'b0;
    end else if (state == IDLE && !req_valid[cur_w]) begin
      lock_q <= 1'b0;
    end
  end
`else
  // plain round-robin grant
  always_comb begin
    grant     = pick_gnt;
    grant_idx = pick_idx;
    grant_any = pick_any;
  end
`endif

  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign accept    = (state == IDLE) && !reset && grant_any;

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // next state and completion strobes
  always_comb begin
    state_d = state;
    fin_ok  = 1'b0;
    fin_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bank_finish) begin
          fin_ok  = 1'b1;
          state_d = IDLE;
        end else if (cnt == TMO_LAST) begin
          fin_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // transaction latch, bank drive and response pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr        <= IW'(N_REQ - 1);
      cur_w      <= '0;
      cur_wr     <= 1'b0;
      cnt        <= '0;
      bank_read  <= 1'b0;
      bank_write <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      if (accept) begin
        cur_w      <= grant_idx;
        cur_wr     <= req_write[grant_idx];
        bank_read  <= !req_write[grant_idx];
        bank_write <= req_write[grant_idx];
        bank_addr  <= req_addr[int'(grant_idx)*AW +: AW];
        bank_wdata <= req_data[int'(grant_idx)*DW +: DW];
      end
      if (state == ISSUE) begin
        bank_read  <= 1'b0;
        bank_write <= 1'b0;
        cnt        <= '0;
      end
      if (state == WAIT && !bank_finish) begin
        cnt <= cnt + 1'b1;
      end
      if (fin_ok || fin_err) begin
        rsp_valid <= ONE << cur_w;
        rsp_err   <= fin_err;
        rsp_data  <= (fin_ok && !cur_wr) ? bank_rdata : '0;
        ptr       <= cur_w;
      end
    end
  end

endmodule

// File: tb/tb_bank_arbiter.sv
// Directed bench for bank_arbiter with a one-cycle bank model.
// Lock checks compile in when BANK_ARB_LOCK_EN is defined.
module tb_bank_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_write;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        bank_read;
  logic        bank_write;
  logic [7:0]  bank_addr;
  logic [7:0]  bank_wdata;
  logic [7:0]  bank_rdata = 8'h00;
  logic        bank_finish = 1'b0;

  logic         fin_en = 1'b1;
  logic [7:0]   mem [256];
  logic [255:0] wmask = '0;

  int tests  = 0;
  int failed = 0;
  int n;

  always #5 clock = ~clock;

  bank_arbiter #(
    .N_REQ   (4),
    .AW      (8),
    .DW      (8),
    .TIMEOUT (15)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_data    (req_data),
`ifdef BANK_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .bank_read   (bank_read),
    .bank_write  (bank_write),
    .bank_addr   (bank_addr),
    .bank_wdata  (bank_wdata),
    .bank_rdata  (bank_rdata),
    .bank_finish (bank_finish)
  );

  // bank: unwritten cells read as addr^3C, finish one cycle after strobe
  always @(posedge clock) begin
    if (bank_write) begin
      mem[bank_addr]   <= bank_wdata;
      wmask[bank_addr] <= 1'b1;
    end
    bank_rdata  <= wmask[bank_addr] ? mem[bank_addr]
                                    : (bank_addr ^ 8'h3C);
    bank_finish <= fin_en & (bank_read | bank_write);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'hF;
    req_write = 4'h0;
    req_addr  = {8'h23, 8'h22, 8'h21, 8'h20};
    req_data  = 32'h0;
    req_lock  = 4'h0;

    // 1: reset held with all requests pending
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", 32'(req_ready), 32'h0);
    end
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_bank_rw", 32'({bank_read, bank_write}), 32'h0);
    chk("rst_bank_addr", 32'(bank_addr), 32'h0);
    chk("rst_bank_wdata", 32'(bank_wdata), 32'h0);
    reset = 1'b0;
    #1;
    chk("rel_ready", 32'(req_ready), 32'h1);
    req_valid = 4'h0;

    // 2: write then read back through requester 1
    req_addr[15:8] = 8'h10;
    req_data[15:8] = 8'hA5;
    req_write = 4'b0010;
    req_valid = 4'b0010;
    #1;
    chk("wr_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'h0;
    chk("wr_strobe", 32'({bank_read, bank_write}), 32'h1);
    chk("wr_addr", 32'(bank_addr), 32'h10);
    chk("wr_wdata", 32'(bank_wdata), 32'hA5);
    chk("wr_c1_ready", 32'(req_ready), 32'h0);
    tick();
    chk("wr_c2_strobe", 32'({bank_read, bank_write}), 32'h0);
    chk("wr_c2_rsp", 32'(rsp_valid), 32'h0);
    tick();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("wr_rsp_data", 32'(rsp_data), 32'h0);
    chk("wr_rsp_err", 32'(rsp_err), 32'h0);
    req_write = 4'b0000;
    req_valid = 4'b0010;
    #1;
    chk("rd_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'h0;
    chk("rd_strobe", 32'({bank_read, bank_write}), 32'h2);
    tick();
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("rd_rsp_data", 32'(rsp_data), 32'hA5);
    chk("rd_rsp_err", 32'(rsp_err), 32'h0);
    tick();
    chk("rd_pulse_end", 32'(rsp_valid), 32'h0);

    // 3: fresh reset, all four requesters valid
    req_addr = {8'h23, 8'h22, 8'h21, 8'h20};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      logic [7:0] exp_d [4];
      exp_d[0] = 8'h1C;
      exp_d[1] = 8'h1D;
      exp_d[2] = 8'h1E;
      exp_d[3] = 8'h1F;
      chk($sformatf("rr_ready%0d", k), 32'(req_ready),
          32'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr_busy%0d", k), 32'(req_ready), 32'h0);
      tick();
      tick();
      chk($sformatf("rr_rsp%0d", k), 32'(rsp_valid),
          32'(4'b0001 << (k % 4)));
      chk($sformatf("rr_data%0d", k), 32'(rsp_data),
          32'(exp_d[k % 4]));
    end
    req_valid = 4'h0;
    tick();

    // 4: bank never finishes -> timeout error
    fin_en = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("to_ready", 32'(req_ready), 32'h4);
    n = 0;
    while (rsp_valid == 4'h0 && n < 40) begin
      tick();
      n++;
      if (n == 1) req_valid = 4'h0;
    end
    chk("to_cycles", 32'(n), 32'd17);
    chk("to_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("to_rsp_err", 32'(rsp_err), 32'h1);
    chk("to_rsp_data", 32'(rsp_data), 32'h0);
    fin_en = 1'b1;
    req_valid = 4'b1001;
    #1;
    chk("to_next_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'h0;
    tick();
    tick();
    chk("to_next_rsp", 32'(rsp_valid), 32'h8);
    chk("to_next_err", 32'(rsp_err), 32'h0);
    chk("to_next_data", 32'(rsp_data), 32'h1F);

    // 5: reset while waiting on the bank
    fin_en = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("rw_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'h0;
    tick();
    reset = 1'b1;
    tick();
    chk("rw_rsp", 32'(rsp_valid), 32'h0);
    chk("rw_strobe", 32'({bank_read, bank_write}), 32'h0);
    reset = 1'b0;
    fin_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rw_no_rsp", 32'(rsp_valid), 32'h0);
    end
    req_valid = 4'hF;
    #1;
    chk("rw_next_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'h0;
    tick();
    tick();
    chk("rw_next_rsp", 32'(rsp_valid), 32'h1);
    chk("rw_next_data", 32'(rsp_data), 32'h1C);

`ifdef BANK_ARB_LOCK_EN
    // 6: requester 2 holds the bank via req_lock
    req_lock = 4'b0100;
    req_valid = 4'b1101;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lk_ready%0d", k), 32'(req_ready), 32'h4);
      tick();
      if (k == 2) req_lock = 4'h0;
      tick();
      tick();
      chk($sformatf("lk_rsp%0d", k), 32'(rsp_valid), 32'h4);
    end
    chk("lk_release", 32'(req_ready), 32'h8);
    req_valid = 4'h0;
    tick();
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
